// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared 4-bit ALU: grants one requester at a time,
// registers its operands into the ALU, waits ALU_LAT cycles, and returns a tagged result.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_A,
  input  logic [4*NUM_REQ-1:0] req_B,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           alu_A,
  output logic [3:0]           alu_B,
  output logic [1:0]           alu_op,
  input  logic [3:0]           alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(ALU_LAT);

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic            accept;
  logic [2:0]      cnt;

  // Rotating priority: scan starts just after the last served requester.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_idx   = last_gnt;
    gnt_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  // Gating with rst keeps req_ready low in the reset cycle even when already IDLE.
  assign accept    = (state == IDLE) && gnt_found && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == LAT) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt     <= ID_W'(NUM_REQ - 1);
      cnt          <= '0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_op       <= '0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_A    <= req_A[4*gnt_idx +: 4];
            alu_B    <= req_B[4*gnt_idx +: 4];
            alu_op   <= req_op[2*gnt_idx +: 2];
            rsp_id   <= gnt_idx;
            last_gnt <= gnt_idx;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != LAT) begin
            cnt <= cnt + 3'd1;
          end else begin
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
          end
        end
        RESP: begin
          if (rsp_ready) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: a registered-ALU instance driven by directed and
// random traffic against a round-robin reference model, plus a combinational-ALU instance.
module tb_alu_rr_scheduler;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Registered-ALU instance
  logic [N-1:0]   req_valid, req_ready;
  logic [4*N-1:0] req_A, req_B;
  logic [2*N-1:0] req_op;
  logic [3:0]     alu_A, alu_B, alu_result, rsp_result;
  logic [1:0]     alu_op, rsp_id;
  logic           alu_carry, alu_zero, alu_overflow;
  logic           rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_overflow, busy;

  // Combinational-ALU instance
  logic [N-1:0]   req_valid_z, req_ready_z;
  logic [4*N-1:0] req_A_z, req_B_z;
  logic [2*N-1:0] req_op_z;
  logic [3:0]     alu_A_z, alu_B_z, alu_result_z, rsp_result_z;
  logic [1:0]     alu_op_z, rsp_id_z;
  logic           alu_carry_z, alu_zero_z, alu_overflow_z;
  logic           rsp_valid_z, rsp_ready_z, rsp_carry_z, rsp_zero_z, rsp_overflow_z, busy_z;

  alu_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
    .req_op(req_op), .req_ready(req_ready), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .busy(busy)
  );

  alu_rr_scheduler #(.NUM_REQ(N), .ID_W(2), .ALU_LAT(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_A(req_A_z), .req_B(req_B_z),
    .req_op(req_op_z), .req_ready(req_ready_z), .alu_A(alu_A_z), .alu_B(alu_B_z),
    .alu_op(alu_op_z), .alu_result(alu_result_z), .alu_carry(alu_carry_z),
    .alu_zero(alu_zero_z), .alu_overflow(alu_overflow_z), .rsp_valid(rsp_valid_z),
    .rsp_ready(rsp_ready_z), .rsp_id(rsp_id_z), .rsp_result(rsp_result_z),
    .rsp_carry(rsp_carry_z), .rsp_zero(rsp_zero_z), .rsp_overflow(rsp_overflow_z),
    .busy(busy_z)
  );

  // Bench ALU: op 0=ADD, 1=SUB, 2=AND, 3=XOR; returns {result, carry, zero, overflow}.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [4:0] s;
    logic       v;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b};        v = (a[3] == b[3]) && (s[3] != a[3]); end
      2'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; v = (a[3] != b[3]) && (s[3] != a[3]); end
      2'd2: begin s = {1'b0, a & b}; v = 1'b0; end
      default: begin s = {1'b0, a ^ b}; v = 1'b0; end
    endcase
    return {s[3:0], s[4], (s[3:0] == 4'd0), v};
  endfunction

  always_ff @(posedge clk)
    {alu_result, alu_carry, alu_zero, alu_overflow} <= alu_fn(alu_A, alu_B, alu_op);
  assign {alu_result_z, alu_carry_z, alu_zero_z, alu_overflow_z} = alu_fn(alu_A_z, alu_B_z, alu_op_z);

  int checks = 0;
  int errors = 0;
  int last_gnt = N - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first valid index after the last served one, wrapping.
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last_gnt + k) % N]) return (last_gnt + k) % N;
    return -1;
  endfunction

  // Entered just after a rising edge with the DUT idle and a nonzero req_valid applied.
  task automatic do_op(input int hold, input string tag);
    int g;
    logic [3:0] a, b;
    logic [1:0] op;
    logic [6:0] e;
    @(negedge clk);
    g = pick(req_valid);
    check({tag, " ready"}, 32'(req_ready), 32'(1 << g));
    a  = req_A[4*g +: 4];
    b  = req_B[4*g +: 4];
    op = req_op[2*g +: 2];
    e  = alu_fn(a, b, op);
    last_gnt = g;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'($urandom);
    req_A     = 16'($urandom) | 16'h000F;
    req_B     = 16'($urandom);
    req_op    = 8'($urandom);
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      check({tag, " alu_A"}, 32'(alu_A), 32'(a));
      check({tag, " alu_B"}, 32'(alu_B), 32'(b));
      check({tag, " alu_op"}, 32'(alu_op), 32'(op));
      check({tag, " wait busy"}, 32'(busy), 32'd1);
      check({tag, " wait rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, " wait ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " rsp_id"}, 32'(rsp_id), 32'(g));
      check({tag, " rsp_result"}, 32'(rsp_result), 32'(e[6:3]));
      check({tag, " rsp_carry"}, 32'(rsp_carry), 32'(e[2]));
      check({tag, " rsp_zero"}, 32'(rsp_zero), 32'(e[1]));
      check({tag, " rsp_overflow"}, 32'(rsp_overflow), 32'(e[0]));
      check({tag, " resp ready"}, 32'(req_ready), 32'd0);
      check({tag, " resp busy"}, 32'(busy), 32'd1);
      if (h == hold) begin
        rsp_ready = 1'b1;
        req_valid = '0;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [N-1:0] exp_ready;
    rst = 1'b1;
    req_valid = '1; req_A = '0; req_B = '0; req_op = '0; rsp_ready = 1'b0;
    req_valid_z = '1; req_A_z = '0; req_B_z = '0; req_op_z = '0; rsp_ready_z = 1'b0;

    // Reset: outputs zero and no grant while rst is high, even with everyone requesting.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst req_ready_z", 32'(req_ready_z), 32'd0);
    check("rst alu_A", 32'(alu_A), 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_id", 32'(rsp_id), 32'd0);
    check("rst rsp_result", 32'(rsp_result), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // Zero-latency ALU: SUB 0-1 answers two cycles after accept.
    req_valid_z = 4'b0001; req_A_z = '0; req_B_z = 16'h0001; req_op_z = 8'h01;
    @(negedge clk);
    check("z ready", 32'(req_ready_z), 32'd1);
    @(posedge clk); #1;
    req_valid_z = '0; rsp_ready_z = 1'b1;
    @(negedge clk);
    check("z t+1 rsp_valid", 32'(rsp_valid_z), 32'd0);
    check("z t+1 alu_B", 32'(alu_B_z), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("z t+2 rsp_valid", 32'(rsp_valid_z), 32'd1);
    check("z rsp_result", 32'(rsp_result_z), 32'hF);
    check("z rsp_zero", 32'(rsp_zero_z), 32'd0);
    check("z rsp_id", 32'(rsp_id_z), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("z exit rsp_valid", 32'(rsp_valid_z), 32'd0);
    @(posedge clk); #1;

    // All requesters valid, consumer always ready: grants every LAT+3 cycles in order.
    req_valid = '1; rsp_ready = 1'b1;
    req_A = 16'($urandom); req_B = 16'($urandom); req_op = 8'($urandom);
    for (int k = 0; k < 5 * (LAT + 3); k++) begin
      @(negedge clk);
      if (k % (LAT + 3) == 0) begin
        g = pick(req_valid);
        exp_ready = N'(1 << g);
        last_gnt = g;
      end else begin
        exp_ready = '0;
      end
      check("b2b ready", 32'(req_ready), 32'(exp_ready));
      @(posedge clk); #1;
      if (k == 4 * (LAT + 3)) req_valid = '0;
    end
    check("b2b last grant", 32'(last_gnt), 32'd0);
    rsp_ready = 1'b0;

    // Directed: requester 2 ADD 9+8 -> 1 with carry and overflow.
    req_valid = 4'b0100; req_A = 16'h0900; req_B = 16'h0800; req_op = 8'h00;
    do_op(0, "dir add");

    // Requester 0 operand A=3 changes to F after accept; do_op forces that change.
    req_valid = 4'b0001; req_A = 16'h0003; req_B = 16'h0002; req_op = 8'h00;
    do_op(0, "operand hold");

    // Back-pressure for 10 cycles, then the next grant continues after the served one.
    req_valid = '1; req_A = 16'($urandom); req_B = 16'($urandom); req_op = 8'($urandom);
    do_op(10, "backpressure");
    req_valid = '1; req_A = 16'($urandom); req_B = 16'($urandom); req_op = 8'($urandom);
    do_op(0, "bp next");

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      do req_valid = 4'($urandom); while (req_valid == '0);
      req_A = 16'($urandom); req_B = 16'($urandom); req_op = 8'($urandom);
      do_op(int'($urandom_range(0, 3)), "random");
    end

    // Reset in WAIT abandons requester 3; requester 0 is granted first afterwards.
    req_valid = 4'b1000; req_A = 16'($urandom); req_B = 16'($urandom);
    @(negedge clk);
    check("pre-rst ready", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '1; rst = 1'b1;
    @(negedge clk);
    check("rst-in-wait ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_gnt = N - 1;
    @(negedge clk);
    check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst alu_A", 32'(alu_A), 32'd0);
    check("post-rst rsp_id", 32'(rsp_id), 32'd0);
    check("post-rst ready", 32'(req_ready), 32'(1 << pick(req_valid)));
    check("post-rst grant0", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
